// File: rtl/counter_slot_scheduler_pkg.sv
// Shared types and constants for the counter slot scheduler.
package counter_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int NUM_REQ_DEF = 4;
  localparam int CNT_W_DEF   = 4;
  localparam int ID_W_DEF    = 2;
  localparam int MAX_REQ     = 8;

  // Wide enough for the largest supported requester count; callers truncate.
  function automatic logic [MAX_REQ-1:0] onehot(input int id);
    onehot = MAX_REQ'(1) << id;
  endfunction

endpackage

// File: rtl/counter_slot_scheduler_if.sv
// Requester-side bus of the counter slot scheduler.
interface counter_slot_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CNT_W-1:0] req_len;
  logic [NUM_REQ-1:0]       grant;
  logic                     busy;
  logic [CNT_W-1:0]         count;
  logic                     done;
  logic [ID_W-1:0]          done_id;

  modport master (
    output req, req_len,
    input  grant, busy, count, done, done_id
  );

  modport slave (
    input  req, req_len,
    output grant, busy, count, done, done_id
  );
endinterface

// File: rtl/counter_slot_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic               valid_o,
  output logic [ID_W-1:0]    id_o
);

  logic [ID_W-1:0] idx;

  // Scan highest offset first so the closest request to ptr wins last.
  always_comb begin
    valid_o = 1'b0;
    id_o    = '0;
    idx     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ID_W'((int'(ptr_i) + i) % NUM_REQ);
      if (req_i[idx]) begin
        valid_o = 1'b1;
        id_o    = idx;
      end
    end
  end

endmodule

// File: rtl/counter_slot_scheduler.sv
// Time-shares one up-counter between requesters, round-robin, one interval per grant.
//   state | meaning
//   IDLE  | no owner; arbitrate when any req is high
//   RUN   | owner's counter advancing from 0 to len_q
//   DONE  | completion cycle; done pulses, then release
module counter_slot_scheduler
  import counter_sched_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int ID_W    = ID_W_DEF
) (
  input  logic clk,
  input  logic reset,
  counter_slot_scheduler_if.slave bus
);

  state_e             state_q;
  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    owner_q;
  logic [CNT_W-1:0]   len_q;
  logic [CNT_W-1:0]   count_q;
  logic [NUM_REQ-1:0] grant_q;
  logic               busy_q;
  logic               done_q;
  logic [ID_W-1:0]    done_id_q;

  logic               win_valid;
  logic [ID_W-1:0]    win_id;
  logic [CNT_W-1:0]   len_d;
  logic [NUM_REQ-1:0] grant_d;
  logic [ID_W-1:0]    ptr_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .valid_o (win_valid),
    .id_o    (win_id)
  );

  assign len_d   = bus.req_len[int'(win_id)*CNT_W +: CNT_W];
  assign grant_d = NUM_REQ'(onehot(int'(win_id)));
  assign ptr_d   = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      len_q     <= '0;
      count_q   <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            owner_q <= win_id;
            len_q   <= len_d;
            count_q <= '0;
            grant_q <= grant_d;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          // Withdrawal wins over completion: no done for an abandoned slot.
          if (!bus.req[owner_q]) begin
            count_q <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= ptr_d;
            state_q <= IDLE;
          end else if (count_q == len_q) begin
            done_q    <= 1'b1;
            done_id_q <= owner_q;
            state_q   <= DONE;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        DONE: begin
          count_q <= '0;
          grant_q <= '0;
          busy_q  <= 1'b0;
          ptr_q   <= ptr_d;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant   = grant_q;
  assign bus.busy    = busy_q;
  assign bus.count   = count_q;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;

endmodule
